// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - keypad column scanner, debouncer and key-code FIFO
//
// Purpose: drives a one-hot column scan over a ROWS x COLS key matrix,
// synchronises and debounces the row returns once per frame, and queues one
// key code per accepted press in a show-ahead FIFO popped by valid/ready.
//
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat every REPEAT_FRAMES
// frames while the accepted key stays pressed).
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   scan_en       1 = scanning enabled; 0 parks the scanner and debouncer
//   row_in        raw active-high row returns (asynchronous)
//   col_out       one-hot active-high column drive
//   key_code      FIFO head code (col*ROWS + row), 0 when empty
//   key_valid     FIFO non-empty
//   key_ready     consumer accepts the head
//   fifo_count    entries held
//   overflow      sticky: a press was dropped on a full FIFO
//   clr_overflow  clears overflow

module keypad_scan_fifo #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE      = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FRAMES = 32,
    localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int FW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_en,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [FW-1:0]   fifo_count,
    output logic            overflow,
    input  logic            clr_overflow
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW  = $clog2(COLS);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int NW  = $clog2(DEBOUNCE + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    // Parameter range guard: an illegal configuration elaborates this block.
    if (SCAN_DIV < 4 || DEBOUNCE < 1 || FIFO_DEPTH < 2 || REPEAT_FRAMES < 1) begin : g_invalid_params
    end

    // ---------------- row synchroniser ----------------
    logic [ROWS-1:0] r_sync1, r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
        end
    end

    // ---------------- column dwell / rotation ----------------
    logic [DW-1:0] r_dwell;
    logic [KW-1:0] r_col;
    logic          w_tick, w_frame_end;

    assign w_tick      = scan_en && (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frame_end = w_tick && (r_col == KW'(COLS - 1));
    assign col_out     = scan_en ? (COLS'(1) << r_col) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_col   <= '0;
        end else if (!scan_en) begin
            r_dwell <= '0;
            r_col   <= '0;
        end else if (w_tick) begin
            r_dwell <= '0;
            r_col   <= (r_col == KW'(COLS - 1)) ? '0 : r_col + KW'(1);
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // ---------------- frame code ----------------
    // Columns are visited in ascending order and rows are priority-encoded
    // lowest first, so the first hit of a frame is its lowest code.
    logic          w_row_hit;
    logic [RW-1:0] w_row_idx;
    logic [CW-1:0] w_tick_code;
    logic          r_acc_hit;
    logic [CW-1:0] r_acc_code;
    logic          w_frame_hit;
    logic [CW-1:0] w_frame_code;

    always_comb begin
        w_row_hit = |r_sync2;
        w_row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (r_sync2[i]) w_row_idx = RW'(i);
        end
    end

    assign w_tick_code  = CW'(r_col) * CW'(ROWS) + CW'(w_row_idx);
    assign w_frame_hit  = r_acc_hit | w_row_hit;
    assign w_frame_code = r_acc_hit ? r_acc_code : w_tick_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hit  <= 1'b0;
            r_acc_code <= '0;
        end else if (!scan_en || w_frame_end) begin
            r_acc_hit  <= 1'b0;
            r_acc_code <= '0;
        end else if (w_tick && !r_acc_hit && w_row_hit) begin
            r_acc_hit  <= 1'b1;
            r_acc_code <= w_tick_code;
        end
    end

    // ---------------- debounce FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_CAND, S_HELD, S_REL} state_t;

    state_t        r_state, w_state_nxt;
    logic [NW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CW-1:0] r_cand, w_cand_nxt;
    logic          w_cnt_done, w_same, w_push;

    assign w_cnt_inc  = r_cnt + NW'(1);
    assign w_cnt_done = (w_cnt_inc == NW'(DEBOUNCE));
    assign w_same     = (w_frame_code == r_cand);

`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_FRAMES + 1);
    logic [RPW-1:0] r_rep, w_rep_nxt, w_rep_inc;
    logic           w_rep_hit;

    assign w_rep_inc = r_rep + RPW'(1);
    assign w_rep_hit = (w_rep_inc == RPW'(REPEAT_FRAMES));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= w_rep_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt   = r_rep;
`endif
        if (!scan_en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
`ifdef KEYPAD_REPEAT_EN
            w_rep_nxt   = '0;
`endif
        end else if (w_frame_end) begin
            case (r_state)
                S_IDLE: if (w_frame_hit) begin
                    w_cand_nxt  = w_frame_code;
                    w_cnt_nxt   = NW'(1);
                    w_state_nxt = (DEBOUNCE == 1) ? S_HELD : S_CAND;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_nxt   = '0;
`endif
                end
                S_CAND: if (!w_frame_hit) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_same) begin
                    w_cand_nxt  = w_frame_code;
                    w_cnt_nxt   = NW'(1);
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_done) w_state_nxt = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_nxt   = '0;
`endif
                end
                S_HELD: if (!w_frame_hit) begin
                    w_state_nxt = (DEBOUNCE == 1) ? S_IDLE : S_REL;
                    w_cnt_nxt   = NW'(1);
`ifdef KEYPAD_REPEAT_EN
                    w_rep_nxt   = '0;
                end else if (w_same) begin
                    w_rep_nxt   = w_rep_hit ? '0 : w_rep_inc;
`endif
                end
                S_REL: if (w_frame_hit) begin
                    w_state_nxt = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_nxt   = '0;
`endif
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_done) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push = 1'b0;
        if (w_frame_end && w_frame_hit) begin
            case (r_state)
                S_IDLE:  w_push = (DEBOUNCE == 1);
                S_CAND:  w_push = w_same && w_cnt_done;
`ifdef KEYPAD_REPEAT_EN
                S_HELD:  w_push = w_same && w_rep_hit;
`endif
                default: w_push = 1'b0;
            endcase
        end
    end

    // ---------------- show-ahead FIFO ----------------
    logic [CW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FW-1:0] r_count;
    logic          r_overflow;
    logic          w_pop, w_full, w_wr, w_ovf_set;

    assign key_valid  = (r_count != '0);
    assign key_code   = key_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

    assign w_pop     = key_valid && key_ready;
    assign w_full    = (r_count == FW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_frame_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + FW'(1);
                2'b01:   r_count <= r_count - FW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)         r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb/tb_keypad_scan_fifo.sv - self-checking bench for keypad_scan_fifo
module tb_keypad_scan_fifo;

    localparam int DEB = 2;
    localparam int RPT = 2;

    logic       clk = 1'b0;
    logic       rst_n, scan_en, key_ready, clr_overflow;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, overflow;
    logic [2:0] fifo_count;
    logic [15:0] keys;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_scan_fifo #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB),
        .FIFO_DEPTH(4), .REPEAT_FRAMES(RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row_in(row_in),
        .col_out(col_out), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .fifo_count(fifo_count), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key connects its column drive to its row return.
    always_comb begin
        row_in = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col_out[c] && keys[c*4+r]) row_in[r] = 1'b1;
    end

    // ---------------- reference model ----------------
    int q[$];
    bit m_ovf;
    bit m_held;
    int m_run_code, m_run_len, m_none_len, m_rep;
    int cyc;

    function automatic int lowest(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_clear_debounce();
        m_held = 0; m_run_len = 0; m_none_len = 0; m_rep = 0;
    endtask

    task automatic model_reset();
        q.delete(); m_ovf = 0; cyc = 0; m_run_code = 0;
        model_clear_debounce();
    endtask

    // One frame result: a press is accepted once the same lowest code has been
    // seen DEB frames in a row; it is released after DEB empty frames.
    task automatic model_frame(input int x, output bit push, output int code);
        push = 0; code = x;
        if (!m_held) begin
            if (x < 0) m_run_len = 0;
            else begin
                if (m_run_len > 0 && x == m_run_code) m_run_len++;
                else begin m_run_code = x; m_run_len = 1; end
                if (m_run_len >= DEB) begin
                    push = 1; m_held = 1; m_none_len = 0; m_rep = 0;
                end
            end
        end else if (x < 0) begin
            m_none_len++; m_rep = 0;
            if (m_none_len >= DEB) begin m_held = 0; m_run_len = 0; end
        end else begin
`ifdef KEYPAD_REPEAT_EN
            if (m_none_len == 0 && x == m_run_code) begin
                m_rep++;
                if (m_rep == RPT) begin push = 1; m_rep = 0; end
            end
`endif
            if (m_none_len > 0) m_rep = 0;
            m_none_len = 0;
        end
    endtask

    // One clock: drive handshake inputs, advance, then update the model.
    task automatic cycle(input bit rdy, input bit clr);
        bit pop, push;
        int code;
        key_ready = rdy; clr_overflow = clr;
        pop = rdy && (q.size() > 0);
        push = 0; code = 0;
        if (!scan_en) model_clear_debounce();
        else if ((cyc + 1) % 16 == 0) model_frame(lowest(keys), push, code);
        @(posedge clk); #1;
        if (push && q.size() == 4 && !pop) m_ovf = 1;
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(code);
            if (clr) m_ovf = 0;
        end
        cyc = scan_en ? cyc + 1 : 0;
    endtask

    task automatic frame(input logic [15:0] k, input bit rdy);
        keys = k;
        for (int i = 0; i < 16; i++) cycle(rdy, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1; scan_en = 1; keys = '0; key_ready = 0; clr_overflow = 0;
        #1 rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (col_out !== 4'b0001) begin n_bad++; $display("FAIL reset_col got=%b exp=0001", col_out); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        @(posedge clk); #1 rst_n = 1;
        cyc = 0;
    endtask

    task automatic test_press();
        keys = 16'(1 << 9);
        for (int i = 0; i < 16; i++) cycle(0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 0);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_early got=%b exp=0", key_valid); end
        cycle(0, 0);
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid got=%b exp=1", key_valid); end
        n_cmp++; if (key_code !== 4'd9) begin n_bad++; $display("FAIL press_code got=%0d exp=9", key_code); end
        frame(16'(1 << 9), 0);
        frame(16'(1 << 9), 0);
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL press_once got=%0d exp=1", fifo_count); end
        for (int f = 0; f < 3; f++) frame('0, 0);
        frame(16'(1 << 9), 0);
        frame(16'(1 << 9), 0);
        n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL press_again got=%0d exp=2", fifo_count); end
    endtask

    task automatic test_reset_mid();
        keys = '0;
        for (int i = 0; i < 6; i++) cycle(0, 0);
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (col_out !== 4'b0001) begin n_bad++; $display("FAIL rmid_col got=%b exp=0001", col_out); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b exp=0", key_valid); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
        @(posedge clk); #1 rst_n = 1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0);
            n_cmp++;
            if (col_out !== 4'(1 << ((cyc / 4) % 4))) begin
                n_bad++; $display("FAIL col_step cyc=%0d got=%b exp=%b", cyc, col_out, 4'(1 << ((cyc / 4) % 4)));
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            frame(16'(1 << 9), 0);
            frame('0, 0);
        end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL bounce got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_multi_key();
        for (int f = 0; f < 3; f++) frame(16'((1 << 3) | (1 << 4)), 0);
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL multi_count got=%0d exp=1", fifo_count); end
        n_cmp++; if (key_code !== 4'd3) begin n_bad++; $display("FAIL multi_code got=%0d exp=3", key_code); end
        frame('0, 1);
        frame('0, 0);
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL multi_pop got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_overflow();
        for (int c = 1; c <= 5; c++) begin
            frame(16'(1 << c), 0); frame(16'(1 << c), 0);
            frame('0, 0); frame('0, 0);
        end
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        n_cmp++; if (key_code !== 4'd1) begin n_bad++; $display("FAIL ovf_head got=%0d exp=1", key_code); end
        keys = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                n_cmp++;
                if (key_code !== 4'(i + 1)) begin n_bad++; $display("FAIL pop_order i=%0d got=%0d exp=%0d", i, key_code, i + 1); end
            end
            if (i == 5) begin
                n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
            end
            cycle(i < 4, i == 5);
        end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL ovf_drain got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_full_pop_push();
        int codes[5] = '{6, 7, 8, 10, 11};
        for (int k = 0; k < 4; k++) begin
            frame(16'(1 << codes[k]), 0); frame(16'(1 << codes[k]), 0);
            frame('0, 0); frame('0, 0);
        end
        frame(16'(1 << 11), 0);
        for (int i = 0; i < 16; i++) cycle(i == 15, 0);
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL pp_count got=%0d exp=4", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
        keys = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                n_cmp++;
                if (key_code !== 4'(codes[i + 1])) begin n_bad++; $display("FAIL pp_order i=%0d got=%0d exp=%0d", i, key_code, codes[i + 1]); end
            end
            cycle(i < 4, 0);
        end
        frame('0, 0);
    endtask

    task automatic test_scan_disable();
        frame(16'(1 << 9), 0);
        scan_en = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0);
            n_cmp++; if (col_out !== 4'b0000) begin n_bad++; $display("FAIL dis_col got=%b exp=0000", col_out); end
        end
        scan_en = 1;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0);
            n_cmp++;
            if (col_out !== 4'(1 << ((cyc / 4) % 4))) begin
                n_bad++; $display("FAIL en_col cyc=%0d got=%b exp=%b", cyc, col_out, 4'(1 << ((cyc / 4) % 4)));
            end
        end
        frame('0, 0); frame('0, 0);
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL dis_nopush got=%0d exp=0", fifo_count); end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        for (int f = 0; f < 8; f++) frame(16'(1 << 9), 0);
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL rpt_count got=%0d exp=4", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rpt_ovf got=%b exp=0", overflow); end
        frame('0, 1);
        frame('0, 0);
    endtask
`endif

    task automatic test_random();
        logic [15:0] prev = '0;
        logic [15:0] k;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    k = '0;
                3, 4, 5, 6: k = prev;
                7, 8:       k = 16'(1 << $urandom_range(0, 15));
                default:    k = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
            endcase
            prev = k; keys = k;
            for (int i = 0; i < 16; i++) begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
                n_cmp++; if (fifo_count !== 3'(q.size())) begin n_bad++; $display("FAIL rnd_count f=%0d got=%0d exp=%0d", f, fifo_count, q.size()); end
                n_cmp++; if (key_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid f=%0d got=%b exp=%b", f, key_valid, q.size() > 0); end
                n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf f=%0d got=%b exp=%b", f, overflow, m_ovf); end
                if (q.size() > 0) begin
                    n_cmp++; if (key_code !== 4'(q[0])) begin n_bad++; $display("FAIL rnd_code f=%0d got=%0d exp=%0d", f, key_code, q[0]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0);
            n_cmp++;
            if (col_out !== 4'(1 << ((cyc / 4) % 4))) begin
                n_bad++; $display("FAIL init_col cyc=%0d got=%b exp=%b", cyc, col_out, 4'(1 << ((cyc / 4) % 4)));
            end
        end
        test_press();
        test_reset_mid();
        test_bounce();
        test_multi_key();
        test_overflow();
        test_full_pop_push();
        test_scan_disable();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised keypad front end for the calculator datapath.
- Drives a one-hot column scan over an ROWS x COLS matrix.
- Synchronises and debounces the row returns with a per-frame FSM.
- Pushes one key code per debounced press into a show-ahead FIFO with a valid/ready pop handshake.
- Feeds the register-bank write path, decoupling keypad timing from datapath consumption.

Parameters:
ROWS, 4, number of row inputs (>=1)
COLS, 4, number of column outputs (>=2)
SCAN_DIV, 1000, clocks each column is driven; must be >=4
DEBOUNCE, 3, consecutive identical frames required to accept a press or release (>=1)
FIFO_DEPTH, 4, key FIFO entries; power of two, >=2
REPEAT_FRAMES, 32, auto-repeat period in frames (used only with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
scan_en  input  1  1 = scanning enabled
row_in  input  ROWS  raw row returns, active-high, asynchronous
col_out  output  COLS  one-hot active-high column drive
key_code  output  CW  FIFO head code; CW = clog2(ROWS*COLS), minimum 1
key_valid  output  1  FIFO non-empty
key_ready  input  1  consumer accepts head
fifo_count  output  clog2(FIFO_DEPTH)+1  entries held
overflow  output  1  sticky: a press was dropped because the FIFO was full
clr_overflow  input  1  clears overflow

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state clears immediately on assertion.
- Reset values:
  - col_out = 1 (column 0); dwell counter = 0; FSM = IDLE.
  - FIFO empty: key_valid = 0, fifo_count = 0, key_code = 0.
  - overflow = 0.
- Synchroniser: row_in passes through a 2-flop synchroniser.
- Column dwell:
  - A column is held SCAN_DIV clocks.
  - The synchronised rows are sampled on the last dwell clock ("tick"), then col_out rotates left (COLS-1 wraps to 0).
  - A frame is COLS ticks. Frame-end is the tick of column COLS-1.
- Frame code:
  - Pressed key at (col c, row r) has code c*ROWS + r.
  - With multiple keys pressed, the lowest code wins.
  - "none" means no key pressed in the frame.
- FSM (advances only at frame-end; frame counter cnt):
  - IDLE: key seen -> CAND with cand = code, cnt = 1.
  - CAND:
    - same code -> cnt++;
    - when cnt reaches DEBOUNCE -> HELD and push cand;
    - different code -> restart CAND with the new code;
    - none -> IDLE.
    - With DEBOUNCE = 1, the push happens on the first frame the key is seen.
  - HELD: none -> REL with cnt = 1; any key -> stay.
  - REL:
    - none -> cnt++; on reaching DEBOUNCE -> IDLE;
    - any key -> back to HELD, with no new push.
- Press latency: the push occurs on the frame-end clock that completes debounce. key_valid/key_code update the next cycle.
- FIFO:
  - Show-ahead: key_code is the head whenever key_valid = 1.
  - A pop occurs when key_valid && key_ready.
  - Pop while empty: ignored.
- Push to a full FIFO:
  - Without a simultaneous pop: the code is dropped, overflow <= 1, contents unchanged.
  - With a simultaneous pop: both take effect, count unchanged, no overflow.
- Overflow flag: clr_overflow clears it. If clr_overflow and a new overflow occur in the same cycle, overflow stays set.
- scan_en = 0:
  - col_out = 0; dwell and frame counters reset to column 0 / count 0; FSM forced to IDLE.
  - FIFO contents, pops and overflow are unaffected.
  - Rising scan_en restarts at column 0 with a full dwell.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. The dwell counter wraps at SCAN_DIV-1.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined:
  - In HELD, a repeat counter counts frames in which the same code is still pressed.
  - Every REPEAT_FRAMES such frames, the code is pushed again, with overflow rules as for a normal push.
  - The counter clears on entering HELD and on any exit from HELD.
- Undefined: exactly one push per press; REPEAT_FRAMES is unused and no repeat logic is synthesised.

Test Plan:
Bench configuration: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4; frame = 16 clocks.
1. Reset: assert rst_n low mid-dwell with FIFO holding 2 entries -> same cycle col_out=0001, key_valid=0, fifo_count=0, overflow=0. Release -> col_out steps 0001/0010/0100/1000 every 4 clocks.
2. Hold row1 during col2 for 4 frames, key_ready=0 -> exactly one entry, key_code=9, key_valid rises 1 clock after the 2nd frame-end. Release 3 frames, press again -> fifo_count=2.
3. Bounce: key 9 pressed 1 frame, off 1 frame, repeated 4 times -> fifo_count stays 0.
4. Keys (col0,row3) and (col1,row0) held together 3 frames -> single entry, key_code=3.
5. Five distinct debounced presses (codes 1,2,3,4,5), key_ready=0 -> fifo_count=4, overflow=1, key_code=1. Pops return 1,2,3,4 in order. clr_overflow pulse -> overflow=0.
6. FIFO full; a push frame-end coincides with key_ready=1 -> fifo_count stays 4, overflow=0, new code at the tail. With KEYPAD_REPEAT_EN and REPEAT_FRAMES=2, holding key 9 for 6 frames after acceptance -> 3 extra pushes of 9.
